// File: rtl/seq_muldiv_32_if.sv
// Request/result bundle for the sequential MUL/DIV unit.
// The master side issues start/op/a/b; the slave side returns status and results.
interface seq_muldiv_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/seq_muldiv_32.sv
// Unsigned 32-bit multiply (radix-2 shift-add) / divide (radix-2 restoring),
// one iteration per clock through a single shared add/sub datapath.
module seq_muldiv_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_muldiv_32_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_rem_shift;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_p_hi_nxt;
  logic [WIDTH-1:0] w_p_lo_nxt;

  // Shared add/sub: b_inv = r_op, so divide computes R' - B_r and carry-out 1 means no borrow.
  assign w_rem_shift = {r_p_hi[WIDTH-2:0], r_p_lo[WIDTH-1]};
  assign w_add_a     = r_op ? w_rem_shift : r_p_hi;
  assign w_add_b     = r_op ? ~r_b : r_b;
  assign w_sum       = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, r_op};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_p_hi_nxt = r_p_hi;
    w_p_lo_nxt = r_p_lo;
    if (!r_op) begin
      if (r_p_lo[0]) {w_p_hi_nxt, w_p_lo_nxt} = {w_sum, r_p_lo[WIDTH-1:1]};
      else           {w_p_hi_nxt, w_p_lo_nxt} = {1'b0, r_p_hi, r_p_lo[WIDTH-1:1]};
    end else if (r_p_hi[WIDTH-1] || w_sum[WIDTH]) begin
      // Bit shifted out of P_hi makes the partial remainder 33 bits wide, so it always fits.
      w_p_hi_nxt = w_sum[WIDTH-1:0];
      w_p_lo_nxt = {r_p_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_p_hi_nxt = w_rem_shift;
      w_p_lo_nxt = {r_p_lo[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (r_state == ST_DONE) r_state <= ST_IDLE;
          if (bus.start) begin
            r_b   <= bus.b;
            r_op  <= bus.op;
            r_cnt <= '0;
            if (bus.op && (bus.b == '0)) begin
              r_p_hi  <= bus.a;
              r_p_lo  <= '1;
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_p_hi  <= '0;
              r_p_lo  <= bus.a;
              r_dbz   <= 1'b0;
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_p_hi <= w_p_hi_nxt;
          r_p_lo <= w_p_lo_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_lo   = r_p_lo;
  assign bus.result_hi   = r_p_hi;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_muldiv_32.sv
// Self-checking bench for seq_muldiv_32: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_seq_muldiv_32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  seq_muldiv_32_if #(.WIDTH(32)) bus ();

  seq_muldiv_32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full 64-bit product, or quotient/remainder; b==0 divide is flagged.
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic dbz, output int lat);
    logic [63:0] p;
    dbz = 1'b0;
    lat = 33;
    if (!op) begin
      p  = 64'(a) * 64'(b);
      lo = p[31:0];
      hi = p[63:32];
    end else if (b == 0) begin
      lo  = 32'hFFFF_FFFF;
      hi  = a;
      dbz = 1'b1;
      lat = 1;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic launch(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'(~op_i);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Called on the first negedge after the accepting edge; returns with done seen (or bound hit).
  task automatic wait_done(input int repulse_at, output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (lat == repulse_at) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result_lo !== 32'h0) begin n_err++; $display("FAIL reset lo: got %h want 0", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'h0) begin n_err++; $display("FAIL reset hi: got %h want 0", bus.result_hi); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset dbz: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_mul_max();
    int lat, bc;
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_max latency: got %0d want 33", lat); end
    n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL mul_max busy cycles: got %0d want 32", bc); end
    n_cmp++; if (bus.result_hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mul_max hi: got %h want fffffffe", bus.result_hi); end
    n_cmp++; if (bus.result_lo !== 32'h0000_0001) begin n_err++; $display("FAIL mul_max lo: got %h want 00000001", bus.result_lo); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL mul_max dbz: got %b want 0", bus.div_by_zero); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mul_max done width: got %b want 0", bus.done); end
    n_cmp++; if (bus.result_lo !== 32'h0000_0001) begin n_err++; $display("FAIL mul_max lo hold: got %h want 00000001", bus.result_lo); end
  endtask

  task automatic test_div_basic();
    int lat, bc;
    launch(1'b1, 32'd100, 32'd7);
    wait_done(0, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div100 latency: got %0d want 33", lat); end
    n_cmp++; if (bus.result_lo !== 32'd14) begin n_err++; $display("FAIL div100 quotient: got %0d want 14", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'd2) begin n_err++; $display("FAIL div100 remainder: got %0d want 2", bus.result_hi); end
    launch(1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(0, lat, bc);
    n_cmp++; if (bus.result_lo !== 32'd1) begin n_err++; $display("FAIL divmsb quotient: got %h want 1", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL divmsb remainder: got %h want 7fffffff", bus.result_hi); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    launch(1'b1, 32'h1234, 32'h0);
    wait_done(0, lat, bc);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dbz latency: got %0d want 1", lat); end
    n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL dbz busy cycles: got %0d want 0", bc); end
    n_cmp++; if (bus.result_lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz lo: got %h want ffffffff", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'h1234) begin n_err++; $display("FAIL dbz hi: got %h want 00001234", bus.result_hi); end
    n_cmp++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz flag: got %b want 1", bus.div_by_zero); end
    launch(1'b0, 32'd3, 32'd5);
    wait_done(0, lat, bc);
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz clear: got %b want 0", bus.div_by_zero); end
    n_cmp++; if (bus.result_lo !== 32'd15) begin n_err++; $display("FAIL mul3x5 lo: got %0d want 15", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'd0) begin n_err++; $display("FAIL mul3x5 hi: got %0d want 0", bus.result_hi); end
  endtask

  task automatic test_restart_ignored();
    int lat, bc;
    launch(1'b0, 32'd6, 32'd7);
    wait_done(10, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL restart latency: got %0d want 33", lat); end
    n_cmp++; if (bus.result_lo !== 32'd42) begin n_err++; $display("FAIL restart lo: got %0d want 42", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'd0) begin n_err++; $display("FAIL restart hi: got %0d want 0", bus.result_hi); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(1'b0, 32'd2, 32'd3);
    wait_done(0, lat, bc);
    n_cmp++; if (bus.result_lo !== 32'd6) begin n_err++; $display("FAIL b2b first lo: got %0d want 6", bus.result_lo); end
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b done: got %b want 0", bus.done); end
    wait_done(0, lat, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b latency: got %0d want 33", lat); end
    n_cmp++; if (bus.result_lo !== 32'd10) begin n_err++; $display("FAIL b2b quotient: got %0d want 10", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'd0) begin n_err++; $display("FAIL b2b remainder: got %0d want 0", bus.result_hi); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, done_seen;
    launch(1'b0, 32'hDEAD_BEEF, 32'h10);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result_lo !== 32'h0) begin n_err++; $display("FAIL rstmid lo: got %h want 0", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'h0) begin n_err++; $display("FAIL rstmid hi: got %h want 0", bus.result_hi); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL rstmid stale activity: got %0d cycles want 0", done_seen); end
    launch(1'b0, 32'h10, 32'h10);
    wait_done(0, lat, bc);
    n_cmp++; if (bus.result_lo !== 32'h100) begin n_err++; $display("FAIL rstmid next lo: got %h want 00000100", bus.result_lo); end
    n_cmp++; if (bus.result_hi !== 32'h0) begin n_err++; $display("FAIL rstmid next hi: got %h want 0", bus.result_hi); end
  endtask

  task automatic test_random();
    int lat, bc, exp_lat;
    logic        op;
    logic [31:0] a, b, exp_lo, exp_hi;
    logic        exp_dbz;
    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (i % 6 == 5) a = 32'hFFFF_FFFF;
      model(op, a, b, exp_lo, exp_hi, exp_dbz, exp_lat);
      launch(op, a, b);
      wait_done(0, lat, bc);
      n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL rand%0d latency: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (bus.result_lo !== exp_lo) begin n_err++; $display("FAIL rand%0d lo op=%b a=%h b=%h: got %h want %h", i, op, a, b, bus.result_lo, exp_lo); end
      n_cmp++; if (bus.result_hi !== exp_hi) begin n_err++; $display("FAIL rand%0d hi op=%b a=%h b=%h: got %h want %h", i, op, a, b, bus.result_hi, exp_hi); end
      n_cmp++; if (bus.div_by_zero !== exp_dbz) begin n_err++; $display("FAIL rand%0d dbz: got %b want %b", i, bus.div_by_zero, exp_dbz); end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_mul_max();
    test_div_basic();
    test_div_zero();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_muldiv_32.md
Name: seq_muldiv_32

Overview:
- Multi-cycle unsigned multiply/divide sequencer built around a single shared 32-bit add/sub datapath.
- The datapath has operands A and B, a b_inv control where 1 means subtract, a sum output, and a carry-out.
- Multiply uses radix-2 shift-add. Divide uses radix-2 restoring division.
- One iteration per clock. Sits beside the ALU in the arithmetics tree as the MUL/DIV execution unit.

Parameters:
- WIDTH, 32, operand width.
  - Only 32 is supported; it sizes the add/sub datapath and the registers.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- op  input  1  0 = multiply, 1 = divide; sampled with start
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse: result valid
- result_lo  output  WIDTH  product[31:0] / quotient
- result_hi  output  WIDTH  product[63:32] / remainder
- div_by_zero  output  1  set when a divide with b==0 completes

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE; counter = 0.
  - Internal registers P_hi, P_lo, B_r, op_r, and the dbz flag are cleared.
  - busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0.
  - An operation in flight is discarded; no done is produced for it.
- States:
  - IDLE: start=1 moves to RUN, except a divide with b==0, which moves directly to DONE.
  - RUN: iterates; after the iteration where counter==WIDTH-1, moves to DONE.
  - DONE: lasts exactly one cycle; done=1. start=1 is accepted here exactly as in IDLE (back-to-back). Otherwise moves to IDLE.
- Start capture, on the edge where start is accepted:
  - B_r=b, op_r=op, counter=0, div_by_zero=0.
  - Multiply: P_hi=0, P_lo=a.
  - Divide: P_hi=0, P_lo=a.
  - Divide with b==0: P_hi=a, P_lo=all-ones, div_by_zero=1, state goes to DONE.
- start in RUN is ignored; no queueing.
- Add/sub datapath connection: A operand = P_hi (divide: shifted P_hi), B operand = B_r, b_inv = op_r.
- Multiply iteration:
  - If P_lo[0]=1: {c,s} = P_hi + B_r. Else: c=0, s=P_hi.
  - {P_hi,P_lo} = {c,s,P_lo[31:1]}, a 65-bit value shifted right by 1.
- Divide iteration:
  - msb=P_hi[31]; R' = {P_hi[30:0],P_lo[31]}; Q' = {P_lo[30:0],0}.
  - Compute R' - B_r; cout=1 means no borrow.
  - If msb=1 or cout=1: P_hi = difference, P_lo = Q' with bit0 = 1.
  - Else: P_hi = R', P_lo = Q'.
  - msb handles the 33-bit partial remainder.
- Latency:
  - Normal operation: start accepted at edge E0 → busy=1 after E0 through E0+32 → done=1 for the cycle after edge E0+32.
  - That is 32 RUN cycles, and done arrives 33 cycles after start was presented.
  - Divide by zero: done=1 in the cycle after E0, busy never asserted.
- Outputs: result_lo=P_lo, result_hi=P_hi (registered). Valid when done=1, held stable until the next accepted start.
- The datapath overflow flag is unused. Only unsigned arithmetic is supported.
- Counter increments only in RUN. It never wraps within an operation.

Test Plan:
- Multiply 0xFFFFFFFF × 0xFFFFFFFF, one start pulse → busy high 32 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- Divide 100 / 7 → done after 32 RUN cycles, lo=14, hi=2. Also divide 0xFFFFFFFF / 0x80000000 → lo=1, hi=0x7FFFFFFF (exercises the msb path).
- Divide 0x1234 / 0 → done in the cycle after accept, busy stays 0, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. A following multiply 3×5 clears div_by_zero and returns lo=15, hi=0.
- Multiply 6×7 with start re-pulsed (a=9, b=9) mid-RUN → the second start is ignored; result lo=42, hi=0 at the original done time.
- Multiply 2×3; in the DONE cycle assert start with divide 50/5 → done for 6, then busy the next cycle, then done 32 cycles later with lo=10, hi=0.
- Multiply 0xDEADBEEF×0x10; pull rst_n low at RUN iteration 10 → busy, done, and results go to 0 immediately (asynchronously). After release, no done occurs until a new start; a subsequent 0x10×0x10 returns lo=0x100.
